// File: rtl/spi_minion_gcd_adapter.sv
// SPI minion bridge between bit-banged firmware SPI frames and the GCD unit's
// val/rdy ports, with small request/response FIFOs and in-frame flow control.
`timescale 1ns/1ps
module spi_minion_gcd_adapter #(
  parameter int PKT_NBITS = 34,
  parameter int DEPTH     = 2
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic        spi_cs_n,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        req_val,
  input  logic        req_rdy,
  output logic [31:0] req_msg,
  input  logic        resp_val,
  output logic        resp_rdy,
  input  logic [31:0] resp_msg,
  output logic        frame_err
);

  localparam int CW = $clog2(PKT_NBITS + 2);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] CNT_FULL = CW'(PKT_NBITS);
  localparam logic [CW-1:0] CNT_SAT  = CW'(PKT_NBITS + 1);
  localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  // cs_n flops reset low so a chip select already asserted at reset release
  // never looks like a falling edge; the adapter waits for a fresh frame.
  logic [2:0] cs_q, sclk_q;
  logic [1:0] mosi_q;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      cs_q   <= '0;
      sclk_q <= '0;
      mosi_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values, which is what makes the shift chain work.
      cs_q   <= {cs_q[1:0], spi_cs_n};
      sclk_q <= {sclk_q[1:0], spi_sclk};
      mosi_q <= {mosi_q[0], spi_mosi};
    end
  end

  logic cs_fall, cs_rise, sclk_rise, sclk_fall, mosi_s;
  assign cs_fall   =  cs_q[2]   & ~cs_q[1];
  assign cs_rise   = ~cs_q[2]   &  cs_q[1];
  assign sclk_rise = ~sclk_q[2] &  sclk_q[1];
  assign sclk_fall =  sclk_q[2] & ~sclk_q[1];
  assign mosi_s    =  mosi_q[1];

  logic [1:0]           state;
  logic [CW-1:0]        bit_cnt;
  logic [PKT_NBITS-1:0] rx_sr, tx_sr;
  logic                 snap_space, snap_avail, miso_oe;

  logic                 req_full, req_empty, resp_full, resp_empty;
  logic [31:0]          resp_head;
  logic                 frame_ok, req_push, req_pop, resp_push, resp_pop;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      rx_sr      <= '0;
      tx_sr      <= '0;
      snap_space <= 1'b0;
      snap_avail <= 1'b0;
      miso_oe    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state      <= SHIFT;
            bit_cnt    <= '0;
            snap_space <= ~req_full;
            snap_avail <= ~resp_empty;
            tx_sr      <= {~req_full, ~resp_empty, resp_empty ? 32'd0 : resp_head};
            miso_oe    <= 1'b1;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state <= COMMIT;
          end else begin
            if (sclk_rise) begin
              rx_sr <= {rx_sr[PKT_NBITS-2:0], mosi_s};
              if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
            end
            if (sclk_fall) tx_sr <= {tx_sr[PKT_NBITS-2:0], 1'b0};
          end
        end
        COMMIT: begin
          state   <= IDLE;
          miso_oe <= 1'b0;
          tx_sr   <= '0;
          if (bit_cnt != '0 && bit_cnt != CNT_FULL) frame_err <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign spi_miso    = tx_sr[PKT_NBITS-1];
  assign spi_miso_oe = miso_oe;

  // Snapshots stay valid until commit: only this point fills the request
  // queue or drains the response queue.
  assign frame_ok  = (state == COMMIT) && (bit_cnt == CNT_FULL);
  assign req_push  = frame_ok & rx_sr[PKT_NBITS-1] & snap_space;
  assign resp_pop  = frame_ok & rx_sr[PKT_NBITS-2] & snap_avail;

  logic [31:0]   req_mem [DEPTH];
  logic [PW-1:0] req_wptr, req_rptr;
  logic [OW-1:0] req_occ;

  assign req_full  = (req_occ == OCC_FULL);
  assign req_empty = (req_occ == '0);
  assign req_val   = ~req_empty;
  assign req_msg   = req_mem[req_rptr];
  assign req_pop   = req_val & req_rdy;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      // NOTE: the storage is reset so req_msg reads zero out of reset; at
      // two entries the reset cost is negligible.
      for (int i = 0; i < DEPTH; i++) req_mem[i] <= '0;
      req_wptr <= '0;
      req_rptr <= '0;
      req_occ  <= '0;
    end else begin
      if (req_push) begin
        req_mem[req_wptr] <= rx_sr[31:0];
        req_wptr          <= req_wptr + 1'b1;
      end
      if (req_pop) req_rptr <= req_rptr + 1'b1;
      case ({req_push, req_pop})
        2'b10:   req_occ <= req_occ + 1'b1;
        2'b01:   req_occ <= req_occ - 1'b1;
        default: req_occ <= req_occ;
      endcase
    end
  end

  logic [31:0]   resp_mem [DEPTH];
  logic [PW-1:0] resp_wptr, resp_rptr;
  logic [OW-1:0] resp_occ;

  assign resp_full  = (resp_occ == OCC_FULL);
  assign resp_empty = (resp_occ == '0);
  assign resp_rdy   = ~resp_full;
  assign resp_head  = resp_mem[resp_rptr];
  assign resp_push  = resp_val & resp_rdy;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < DEPTH; i++) resp_mem[i] <= '0;
      resp_wptr <= '0;
      resp_rptr <= '0;
      resp_occ  <= '0;
    end else begin
      if (resp_push) begin
        resp_mem[resp_wptr] <= resp_msg;
        resp_wptr           <= resp_wptr + 1'b1;
      end
      if (resp_pop) resp_rptr <= resp_rptr + 1'b1;
      case ({resp_push, resp_pop})
        2'b10:   resp_occ <= resp_occ + 1'b1;
        2'b01:   resp_occ <= resp_occ - 1'b1;
        default: resp_occ <= resp_occ;
      endcase
    end
  end

endmodule
